output_arbiter: RTL and testbench
=================================

# output_arbiter

Per-output-port arbiter placed directly downstream of the route-compute stage in each router. It receives the 23-bit routed flits (16-bit data, 4-bit destination address, 3-bit target code) from all five input ports. It keeps only the flits whose target code matches the output port it serves, buffering them in a small FIFO per input. It then forwards one flit per cycle, chosen round-robin, to the output link under a valid/ready handshake. A router instantiates five copies, one per target code.

## Interface
- `PORT_ID`, default 3'b001: target code this instance serves.
  - 3'b001 = +x, 3'b010 = -y, 3'b011 = -x, 3'b100 = +y, 3'b101 = local.
  - 3'b000 is never legal.
- `DEPTH`, default 2: entries per input FIFO. Legal values are 2 or 4.

- `clk`  in  1: the single clock; all state updates on its rising edge.
- `RST`  in  1: reset, asynchronous and active-low.
- `in_data`  in  115: five packed route-compute outputs; input i occupies bits [23*i+22 : 23*i].
  - Per lane: [22:7] data, [6:3] addr, [2:0] target.
- `in_valid`  in  5: per-input valid, one bit per lane.
- `out_data`  out  20: forwarded flit, {data, addr} (target code stripped).
- `out_valid`  out  1: out_data holds a flit.
- `out_ready`  in  1: downstream accepts the flit this cycle.
- `overflow`  out  5: sticky per-input flag; set when a matching flit was dropped.

## Operation
- **Capture:** lane i is written into FIFO i when in_valid[i]=1 and in_data lane i [2:0]==PORT_ID. The written word is lane bits [22:3].
  - Lanes with a non-matching target are ignored.
  - A lane with valid=1 and target 000 is ignored.
- **FIFO:** each FIFO has DEPTH entries, a count 0..DEPTH, and wrapping read/write pointers (log2 DEPTH bits).
  - Write and pop in the same cycle are allowed at any count; the count is unchanged.
  - Write while count==DEPTH with no pop in that cycle: the flit is dropped, FIFO contents are unchanged, and overflow[i] is set.
  - Write while count==DEPTH with a pop of the same FIFO in that cycle: the flit is accepted, not dropped.
- **Output register:** out_data/out_valid are registered. The register is free when out_valid==0 or (out_valid && out_ready).
  - When free and at least one FIFO is non-empty, the grant is the first non-empty FIFO in the order rr_ptr, rr_ptr+1, …, modulo 5.
  - The granted FIFO pops its head into out_data and out_valid becomes 1.
  - rr_ptr then becomes (grant+1) mod 5.
  - When free and all FIFOs are empty, out_valid becomes 0. out_data holds its last value.
  - When not free (out_valid && !out_ready), out_data, out_valid, rr_ptr and all FIFO heads are held unchanged.
- **Arbitration input:** the grant uses FIFO counts from before the current cycle's writes. There is no bypass from in_data to out_data.
- **overflow[i]:** cleared only by reset.

## Timing
- **Reset (async, RST=0):** out_valid=0, out_data=20'b0, overflow=5'b0, rr_ptr=0, all FIFO counts and pointers 0. Flits in flight are discarded.
- **Latency:** a matching flit presented in cycle n with an empty FIFO and a free output register appears with out_valid=1 in cycle n+2.
- **Throughput:** 1 flit/cycle while out_ready stays 1 and any FIFO is non-empty.
- **Simultaneous arrivals:** multiple lanes matching in the same cycle are all written, each into its own FIFO.
- **Back-pressure:** while out_ready=0 the FIFOs keep filling until they drop.
- **Ordering:** per-input order is preserved; no ordering is guaranteed between inputs.
- **Pointers:** each wraps from DEPTH-1 to 0. rr_ptr wraps from 4 to 0.

## Test plan
- **Reset values:** assert RST=0 mid-traffic → next cycle out_valid=0, out_data=0, overflow=0. After release, the first flit needs the full 2-cycle latency.
- **Single flit:** PORT_ID=3'b001; cycle 0 lane 2 valid with {data=16'hBEEF, addr=4'h6, target=001}, out_ready=1 → cycle 2 out_valid=1, out_data=20'hBEEF6. Cycle 3 out_valid=0.
- **Target filter:** same cycle, lane 0 target=011 and lane 4 target=001, both valid → only the lane 4 flit appears; overflow stays 0.
- **Round-robin:** all five lanes each send one matching flit in cycle 0, with out_ready=1 → out_data order is lanes 0, 1, 2, 3, 4 on cycles 2–6. A second burst starts at lane 0 again (rr_ptr=0).
- **Back-pressure and overflow:** DEPTH=2, out_ready=0; lane 1 sends matching flits A, B, C, D on consecutive cycles.
  - A goes to the output register; B and C fill FIFO 1; D is dropped and overflow[1]=1.
  - After out_ready=1: out_data sequence A, B, C; overflow[1] stays 1.
- **Full plus simultaneous pop:** FIFO 3 full and head being granted with out_ready=1, while lane 3 presents a new matching flit in the same cycle → flit accepted, overflow[3] stays 0, all three flits emerge in order.

Source files
------------

// File: rtl/output_arbiter.sv
// Output-port arbiter: filters routed flits by target code into one small FIFO per input,
// then forwards one flit per cycle round-robin into a registered valid/ready output.
module output_arbiter #(
    parameter logic [2:0] PORT_ID = 3'b001,
    parameter int         DEPTH   = 2
) (
    input  logic         clk,
    input  logic         RST,
    input  logic [114:0] in_data,
    input  logic [4:0]   in_valid,
    output logic [19:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [4:0]   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [19:0]   mem    [5][DEPTH];
    logic [AW-1:0] wr_ptr [5];
    logic [AW-1:0] rd_ptr [5];
    logic [CW-1:0] count  [5];

    logic [4:0] wr_req;
    logic [4:0] nonempty;
    logic [4:0] accept;
    logic [4:0] pop;
    logic [2:0] rr_ptr;
    logic [2:0] grant;
    logic       grant_vld;
    logic       out_free;
    logic [3:0] scan_idx;
    logic [19:0] head_word;

    // Handshake: a flit transfers on a rising edge where out_valid && out_ready; while
    // out_valid && !out_ready the output register and everything behind it is held.
    assign out_free = !out_valid || out_ready;

    always_comb begin
        wr_req   = '0;
        nonempty = '0;
        for (int i = 0; i < 5; i++) begin
            wr_req[i]   = in_valid[i] && (in_data[23*i +: 3] == PORT_ID) &&
                          (in_data[23*i +: 3] != 3'b000);
            nonempty[i] = (count[i] != '0);
        end
    end

    // Scan from the farthest candidate back to rr_ptr so the closest non-empty FIFO wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        scan_idx  = '0;
        for (int k = 4; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr} + 4'(k);
            if (scan_idx >= 4'd5) scan_idx = scan_idx - 4'd5;
            if (nonempty[scan_idx[2:0]]) begin
                grant     = scan_idx[2:0];
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        pop    = '0;
        accept = '0;
        for (int i = 0; i < 5; i++) begin
            pop[i]    = out_free && grant_vld && (grant == 3'(i));
            accept[i] = wr_req[i] && ((count[i] != CW'(DEPTH)) || pop[i]);
        end
    end

    assign head_word = mem[grant][rd_ptr[grant]];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (accept[i]) mem[i][wr_ptr[i]] <= in_data[23*i+3 +: 20];
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 5; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            overflow  <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (accept[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                if (accept[i] && !pop[i])      count[i] <= count[i] + CW'(1);
                else if (!accept[i] && pop[i]) count[i] <= count[i] - CW'(1);
                if (wr_req[i] && !accept[i])   overflow[i] <= 1'b1;
            end
            if (out_free) begin
                if (grant_vld) begin
                    out_valid <= 1'b1;
                    out_data  <= head_word;
                    rr_ptr    <= (grant == 3'd4) ? 3'd0 : grant + 3'd1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: stimulus pushes expected flits into a queue and a
// negedge monitor pops and compares every accepted output flit.
module tb_output_arbiter;

    logic         clk;
    logic         RST;
    logic [114:0] in_data;
    logic [4:0]   in_valid;
    logic [19:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   overflow;

    logic [19:0] exp_q[$];
    int n_total;
    int n_pass;

    output_arbiter #(.PORT_ID(3'b001), .DEPTH(2)) dut (
        .clk       (clk),
        .RST       (RST),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [22:0] flit(input logic [15:0] d, input logic [3:0] a,
                                         input logic [2:0] t);
        return {d, a, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [22:0] f);
        in_data[23*i +: 23] = f;
        in_valid[i]         = 1'b1;
    endtask

    task automatic clear_lanes();
        in_data  = '0;
        in_valid = '0;
    endtask

    task automatic burst(input logic [15:0] base);
        step();
        for (int i = 0; i < 5; i++) begin
            set_lane(i, flit(base + 16'(i), 4'(i), 3'b001));
            exp_q.push_back({base + 16'(i), 4'(i)});
        end
        step(); clear_lanes();
        step(); check("rr_first_valid", 32'(out_valid), 32'd1);
        repeat (4) step();
        check("rr_last_valid", 32'(out_valid), 32'd1);
        step(); check("rr_after_valid", 32'(out_valid), 32'd0);
    endtask

    // Monitor: compare every flit the DUT hands over against the scoreboard head.
    always @(negedge clk) begin
        if (RST && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: got %h expected none", out_data);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total   = 0;
        n_pass    = 0;
        RST       = 1'b0;
        out_ready = 1'b1;
        clear_lanes();
        step(); step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        RST = 1'b1;

        // Single flit latency
        step();
        set_lane(2, flit(16'hBEEF, 4'h6, 3'b001));
        exp_q.push_back(20'hBEEF6);
        step(); clear_lanes();
        check("single_c1_valid", 32'(out_valid), 32'd0);
        step();
        check("single_c2_valid", 32'(out_valid), 32'd1);
        check("single_c2_data", 32'(out_data), 32'h000BEEF6);
        step();
        check("single_c3_valid", 32'(out_valid), 32'd0);

        // Target filter, including an illegal target 000
        step();
        set_lane(0, flit(16'h1111, 4'h1, 3'b011));
        set_lane(1, flit(16'h2222, 4'h2, 3'b000));
        set_lane(4, flit(16'h4444, 4'h4, 3'b001));
        exp_q.push_back(20'h44444);
        step(); clear_lanes();
        step(); check("filter_valid", 32'(out_valid), 32'd1);
        step(); check("filter_after_valid", 32'(out_valid), 32'd0);
        check("filter_overflow", 32'(overflow), 32'd0);

        // Round-robin: two bursts, each drained in lane order 0..4
        burst(16'hA000);
        burst(16'hC000);

        // Back-pressure and overflow on lane 1
        out_ready = 1'b0;
        step(); set_lane(1, flit(16'hD00A, 4'h1, 3'b001)); exp_q.push_back(20'hD00A1);
        step(); set_lane(1, flit(16'hD00B, 4'h1, 3'b001)); exp_q.push_back(20'hD00B1);
        step(); set_lane(1, flit(16'hD00C, 4'h1, 3'b001)); exp_q.push_back(20'hD00C1);
        step(); set_lane(1, flit(16'hD00D, 4'h1, 3'b001));
        step(); clear_lanes();
        check("bp_overflow", 32'(overflow), 32'h2);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_data", 32'(out_data), 32'h000D00A1);
        step(); out_ready = 1'b1;
        repeat (5) step();
        check("bp_drained_valid", 32'(out_valid), 32'd0);
        check("bp_overflow_sticky", 32'(overflow), 32'h2);

        // Reset in the middle of held traffic
        out_ready = 1'b0;
        step(); set_lane(0, flit(16'h5555, 4'h5, 3'b001));
        step(); set_lane(0, flit(16'h6666, 4'h6, 3'b001));
        step(); clear_lanes();
        step();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        RST = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        step(); RST = 1'b1; out_ready = 1'b1;
        step();
        set_lane(3, flit(16'h7777, 4'h7, 3'b001));
        exp_q.push_back(20'h77777);
        step(); clear_lanes();
        check("post_rst_c1_valid", 32'(out_valid), 32'd0);
        step();
        check("post_rst_c2_valid", 32'(out_valid), 32'd1);
        step();

        // FIFO 3 full while its head is popped: new flit accepted, not dropped
        out_ready = 1'b0;
        step(); set_lane(3, flit(16'h9000, 4'h3, 3'b001)); exp_q.push_back(20'h90003);
        step(); set_lane(3, flit(16'h9001, 4'h3, 3'b001)); exp_q.push_back(20'h90013);
        step(); set_lane(3, flit(16'h9002, 4'h3, 3'b001)); exp_q.push_back(20'h90023);
        step(); set_lane(3, flit(16'h9003, 4'h3, 3'b001)); exp_q.push_back(20'h90033);
        out_ready = 1'b1;
        step(); clear_lanes();
        repeat (6) step();
        check("full_pop_overflow", 32'(overflow), 32'd0);
        check("full_pop_valid", 32'(out_valid), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
